memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline stage downstream of the execute stage; the consumer side of the execute-to-memory interface.
- Registers the execute outputs: ALU result, store data, condition flags and control bits.
- Runs the data-memory access over a req/ack handshake and stalls upstream stages while the access is pending.
- Presents the completed instruction to writeback.

Parameters:
- WIDTH, 8, datapath width (ALU result, address, store/load data).
- REGADDR, 4, destination register index width.
- TIMEOUT, 16, access timeout in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ValidE  input  1  execute stage holds a valid instruction.
- ALUResultE  input  WIDTH  ALU result; also the memory address.
- WriteDataE  input  WIDTH  store data.
- ALUFlags  input  4  NZCV from the ALU.
- FlagWriteE  input  1  update the flag register.
- MemWriteE  input  1  store.
- MemtoRegE  input  1  load.
- RegWriteE  input  1  instruction writes the register file.
- WA3E  input  REGADDR  destination register.
- StallM  output  1  hold upstream stages.
- ValidM  output  1  instruction completes this cycle.
- ALUResultM  output  WIDTH  registered ALU result.
- ReadDataM  output  WIDTH  load data.
- MemtoRegM  output  1  registered load flag.
- RegWriteM  output  1  registered RegWrite, gated by validity.
- WA3M  output  REGADDR  registered destination.
- FlagsM  output  4  architectural NZCV register.
- mem_req  output  1  access request.
- mem_we  output  1  1 = write.
- mem_addr  output  WIDTH  equals ALUResultM.
- mem_wdata  output  WIDTH  registered store data.
- mem_rdata  input  WIDTH  read data, valid with mem_ack.
- mem_ack  input  1  access complete.

Behaviour:
- Reset (asynchronous): all M registers, FlagsM and ReadDataM go to 0; FSM goes to IDLE. mem_req, StallM and ValidM are 0 immediately. An access in progress is dropped; a late mem_ack in IDLE is ignored.
- Capture: on each rising edge with StallM=0, load ALUResultE, WriteDataE, WA3E, MemtoRegE and MemWriteE into the M registers, and load vM=ValidE. RegWriteM is stored as RegWriteE&ValidE.
- Flags: FlagsM <= ALUFlags on an edge where ValidE & FlagWriteE & !StallM; otherwise FlagsM holds.
- FSM states:
  - IDLE: an edge that captures a valid memory op (MemtoRegE|MemWriteE) moves to ACCESS; otherwise stay in IDLE.
  - ACCESS: mem_req=1, mem_we=MemWriteM. On mem_ack: ReadDataM <= mem_rdata (loads only); next state is ACCESS if the instruction captured on the same edge is a valid memory op, else IDLE. Back-to-back accesses therefore keep mem_req high.
- StallM = (state==ACCESS) & !mem_ack. It is combinational, so zero-wait memory (ack in the first request cycle) adds no stall.
- ValidM:
  - Non-memory op in IDLE: ValidM = vM.
  - Memory op in ACCESS: ValidM = mem_ack.
  - ValidM is 0 while stalled.
- ReadDataM latency: valid the cycle after ack. Writeback samples it from its own pipeline register.
- mem_addr, mem_wdata and mem_we stay stable for the whole request.
- Ack outside ACCESS is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - At count == TIMEOUT-1 without ack, the access aborts: mem_req drops next cycle, ReadDataM <= 0, and ValidM pulses with RegWriteM forced 0.
  - Extra output MemErrM (1 bit) is a one-cycle pulse on abort.
- Undefined: no counter, no MemErrM port; the block waits for ack indefinitely.

Decomposition:
- Shared package `cpu_pkg`:
  - mem_state_t enum {IDLE, ACCESS}.
  - Flag bit index constants N=3, Z=2, C=1, V=0.
  - Default WIDTH/REGADDR localparams.
- Sub-module: `ex_mem_reg`, the parameterised enable-with-async-reset pipeline register used for all M-side state; it is reused for the M/W register.

Test Plan:
- Non-memory op: ADD, ALUResultE=8'h2A, RegWriteE=1, WA3E=3 -> next cycle ALUResultM=2A, WA3M=3, ValidM=1, StallM=0, mem_req=0.
- Zero-wait load: addr 8'h10, mem_ack in the first request cycle with rdata 8'h5C -> StallM never 1; ReadDataM=5C the cycle after ack.
- 3-wait store: addr 8'h20, data 8'hA5, ack on the 4th request cycle -> StallM=1 for 3 cycles; mem_addr/mem_wdata/mem_we stable; exactly one ValidM; the upstream instruction is held and captured on the ack edge.
- Flags: FlagWriteE=1 with ALUFlags=4'b0110 while stalled -> FlagsM unchanged; loaded 0110 on the first unstalled edge. FlagWriteE=0 -> FlagsM holds.
- Reset mid-access: assert reset in the 2nd wait cycle -> mem_req/StallM drop asynchronously; all outputs 0; a stray ack after release is ignored with state=IDLE.
- MEM_TIMEOUT_EN, TIMEOUT=16, no ack -> MemErrM pulses once after 16 request cycles; RegWriteM=0, ReadDataM=0; the next instruction proceeds.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: memory-stage FSM states, NZCV bit
// positions, default datapath sizes and a small memory-op helper.
package cpu_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // NZCV bit positions inside a 4-bit flag vector
    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_REGADDR = 4;

    // A valid instruction that touches data memory (load or store)
    function automatic logic is_mem_op(input logic valid, input logic load, input logic store);
        return valid & (load | store);
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the data memory (slave).
interface memory_stage_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/ex_mem_reg.sv
// Generic enable-gated pipeline register with asynchronous clear.
// Holds all M-side state and is reused for the M/W boundary.
module ex_mem_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load on enable, clear immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: registers execute results, runs the data-memory
// req/ack access, stalls upstream while an access is outstanding and
// presents the completed instruction to writeback.
// Optional build macro MEM_TIMEOUT_EN adds an access watchdog that aborts
// after TIMEOUT request cycles without ack and reports it on MemErrM.
module memory_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REGADDR = DEF_REGADDR,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ValidE,
    input  logic [WIDTH-1:0]   ALUResultE,
    input  logic [WIDTH-1:0]   WriteDataE,
    input  logic [3:0]         ALUFlags,
    input  logic               FlagWriteE,
    input  logic               MemWriteE,
    input  logic               MemtoRegE,
    input  logic               RegWriteE,
    input  logic [REGADDR-1:0] WA3E,
    output logic               StallM,
    output logic               ValidM,
    output logic [WIDTH-1:0]   ALUResultM,
    output logic [WIDTH-1:0]   ReadDataM,
    output logic               MemtoRegM,
    output logic               RegWriteM,
    output logic [REGADDR-1:0] WA3M,
    output logic [3:0]         FlagsM,
`ifdef MEM_TIMEOUT_EN
    output logic               MemErrM,
`endif
    memory_stage_if.master     mem
);

    localparam int MW = 2 * WIDTH + REGADDR + 4;

    mem_state_t       state, state_next;
    logic [MW-1:0]    mreg_p0, mreg_p1;
    logic [WIDTH-1:0] wdata_p1;
    logic             memwrite_p1;
    logic             rw_p1;
    logic             vm_p1;
    logic             cap_mem;
    logic             done;
    logic             rd_en;
    logic [WIDTH-1:0] rd_d;

    // E -> M boundary: RegWrite is qualified by validity before storage
    assign mreg_p0 = {ALUResultE, WriteDataE, WA3E, MemtoRegE, MemWriteE,
                      RegWriteE & ValidE, ValidE};

    ex_mem_reg #(.W(MW)) u_mreg (
        .clk   (clk),
        .reset (reset),
        .en    (!StallM),
        .d     (mreg_p0),
        .q     (mreg_p1)
    );

    assign {ALUResultM, wdata_p1, WA3M, MemtoRegM, memwrite_p1, rw_p1, vm_p1} = mreg_p1;

    // Architectural flags only move when a valid flag-setting op is accepted
    ex_mem_reg #(.W(4)) u_flags (
        .clk   (clk),
        .reset (reset),
        .en    (ValidE & FlagWriteE & !StallM),
        .d     (ALUFlags),
        .q     (FlagsM)
    );

    // Load data lands here on the completing edge; W samples it next cycle
    ex_mem_reg #(.W(WIDTH)) u_rdata (
        .clk   (clk),
        .reset (reset),
        .en    (rd_en),
        .d     (rd_d),
        .q     (ReadDataM)
    );

    assign cap_mem       = is_mem_op(ValidE, MemtoRegE, MemWriteE);
    assign mem.mem_addr  = ALUResultM;
    assign mem.mem_wdata = wdata_p1;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             abort;

    assign abort     = (state == ACCESS) & !mem.mem_ack & (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign done      = mem.mem_ack | abort;
    assign rd_en     = (state == ACCESS) & ((mem.mem_ack & MemtoRegM) | abort);
    assign rd_d      = abort ? '0 : mem.mem_rdata;
    assign RegWriteM = rw_p1 & !abort;
    assign MemErrM   = abort;

    // Wait counter restarts for every newly launched access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!StallM && state_next == ACCESS) begin
            wait_cnt <= '0;
        end else if (state == ACCESS) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    // TIMEOUT only shapes the watchdog, which this build leaves out
    localparam int unused_timeout = TIMEOUT;

    assign done      = mem.mem_ack;
    assign rd_en     = (state == ACCESS) & mem.mem_ack & MemtoRegM;
    assign rd_d      = mem.mem_rdata;
    assign RegWriteM = rw_p1;
`endif

    // Access FSM state register; reset drops any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, request and stall/valid generation; ack is only honoured in ACCESS
    always_comb begin
        state_next  = state;
        StallM      = 1'b0;
        ValidM      = vm_p1;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        case (state)
            IDLE: begin
                if (cap_mem) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = memwrite_p1;
                StallM      = !done;
                ValidM      = done;
                if (done) begin
                    state_next = cap_mem ? ACCESS : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios with literal expectations,
// then randomized traffic against an instruction-level reference model.
module tb_memory_stage;

    localparam int W  = 8;
    localparam int RA = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          ValidE, FlagWriteE, MemWriteE, MemtoRegE, RegWriteE;
    logic [W-1:0]  ALUResultE, WriteDataE;
    logic [3:0]    ALUFlags;
    logic [RA-1:0] WA3E;
    logic          StallM, ValidM, MemtoRegM, RegWriteM;
    logic [W-1:0]  ALUResultM, ReadDataM;
    logic [RA-1:0] WA3M;
    logic [3:0]    FlagsM;

    memory_stage_if #(.WIDTH(W)) mif ();

    memory_stage #(.WIDTH(W), .REGADDR(RA), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .ValidE     (ValidE),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .ALUFlags   (ALUFlags),
        .FlagWriteE (FlagWriteE),
        .MemWriteE  (MemWriteE),
        .MemtoRegE  (MemtoRegE),
        .RegWriteE  (RegWriteE),
        .WA3E       (WA3E),
        .StallM     (StallM),
        .ValidM     (ValidM),
        .ALUResultM (ALUResultM),
        .ReadDataM  (ReadDataM),
        .MemtoRegM  (MemtoRegM),
        .RegWriteM  (RegWriteM),
        .WA3M       (WA3M),
        .FlagsM     (FlagsM),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the instruction currently held in M and whether its
    // memory access is still open.
    logic [W-1:0]  m_alu = '0, m_wd = '0, m_rd = '0;
    logic [RA-1:0] m_wa = '0;
    logic [3:0]    m_flags = '0;
    logic          m_ld = 1'b0, m_st = 1'b0, m_v = 1'b0, m_rw = 1'b0;
    logic          open = 1'b0;
    logic          prev_stall = 1'b0;

    // Compare on the falling edge, then advance the model to the next rising edge
    always @(negedge clk) begin : compare
        logic e_stall, e_valid;
        if (reset) begin
            m_alu = '0; m_wd = '0; m_rd = '0; m_wa = '0; m_flags = '0;
            m_ld = 1'b0; m_st = 1'b0; m_v = 1'b0; m_rw = 1'b0; open = 1'b0;
        end
        e_stall = open & !mif.mem_ack;
        e_valid = open ? mif.mem_ack : m_v;
        chk("ALUResultM", ALUResultM, m_alu);
        chk("WA3M", WA3M, m_wa);
        chk("MemtoRegM", MemtoRegM, m_ld);
        chk("RegWriteM", RegWriteM, m_rw);
        chk("FlagsM", FlagsM, m_flags);
        chk("ReadDataM", ReadDataM, m_rd);
        chk("mem_addr", mif.mem_addr, m_alu);
        chk("mem_wdata", mif.mem_wdata, m_wd);
        chk("mem_req", mif.mem_req, open);
        chk("mem_we", mif.mem_we, open & m_st);
        chk("StallM", StallM, e_stall);
        chk("ValidM", ValidM, e_valid);
        prev_stall = reset ? 1'b0 : e_stall;
        if (!reset) begin
            if (open && mif.mem_ack && m_ld) m_rd = mif.mem_rdata;
            if (!e_stall) begin
                if (ValidE && FlagWriteE) m_flags = ALUFlags;
                m_alu = ALUResultE;
                m_wd  = WriteDataE;
                m_wa  = WA3E;
                m_ld  = MemtoRegE;
                m_st  = MemWriteE;
                m_v   = ValidE;
                m_rw  = RegWriteE & ValidE;
                open  = ValidE & (MemtoRegE | MemWriteE);
            end
        end
    end

    // Memory responder: each access gets lat_cfg wait cycles before ack;
    // outside an access, stray acks are thrown in.
    int lat_cfg  = 0;
    int lat_left = 0;
    bit fresh    = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
        if (open) begin
            if (fresh) begin
                lat_left = lat_cfg;
                fresh    = 1'b0;
            end
            if (lat_left == 0) begin
                mif.mem_ack = 1'b1;
                fresh       = 1'b1;
            end else begin
                mif.mem_ack = 1'b0;
                lat_left--;
            end
        end else begin
            mif.mem_ack = ($urandom_range(0, 3) == 0);
            fresh       = 1'b1;
        end
        mif.mem_rdata = W'($urandom);
    endtask

    task automatic put(input logic v, input logic fw, input logic ld, input logic st,
                       input logic rw, input logic [W-1:0] alu, input logic [W-1:0] wd,
                       input logic [RA-1:0] wa, input logic [3:0] fl);
        ValidE     = v;
        FlagWriteE = fw;
        MemtoRegE  = ld;
        MemWriteE  = st;
        RegWriteE  = rw;
        ALUResultE = alu;
        WriteDataE = wd;
        WA3E       = wa;
        ALUFlags   = fl;
    endtask

    initial begin
        put(0, 0, 0, 0, 0, '0, '0, '0, '0);
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        #2;
        chk("rst_StallM", StallM, 0);
        chk("rst_ValidM", ValidM, 0);
        chk("rst_mem_req", mif.mem_req, 0);
        chk("rst_ALUResultM", ALUResultM, 0);
        chk("rst_FlagsM", FlagsM, 0);
        chk("rst_ReadDataM", ReadDataM, 0);
        tick();
        tick();
        reset = 1'b0;

        // Non-memory ADD, also sets flags to 1001
        put(1, 1, 0, 0, 1, 8'h2A, 8'h00, 4'd3, 4'b1001);
        tick();
        put(0, 0, 0, 0, 0, '0, '0, '0, '0);
        #2;
        chk("add_ALUResultM", ALUResultM, 8'h2A);
        chk("add_WA3M", WA3M, 3);
        chk("add_ValidM", ValidM, 1);
        chk("add_StallM", StallM, 0);
        chk("add_mem_req", mif.mem_req, 0);
        chk("add_RegWriteM", RegWriteM, 1);
        chk("add_FlagsM", FlagsM, 4'b1001);

        // Zero-wait load
        lat_cfg = 0;
        put(1, 0, 1, 0, 1, 8'h10, 8'h00, 4'd5, 4'h0);
        tick();
        mif.mem_rdata = 8'h5C;
        put(0, 0, 0, 0, 0, '0, '0, '0, '0);
        #2;
        chk("zw_StallM", StallM, 0);
        chk("zw_mem_req", mif.mem_req, 1);
        chk("zw_mem_addr", mif.mem_addr, 8'h10);
        chk("zw_ValidM", ValidM, 1);
        tick();
        #2;
        chk("zw_ReadDataM", ReadDataM, 8'h5C);
        chk("zw_req_drop", mif.mem_req, 0);

        // 3-wait store; flag-setting op waits upstream
        lat_cfg = 3;
        put(1, 0, 0, 1, 0, 8'h20, 8'hA5, 4'd0, 4'h0);
        tick();
        put(1, 1, 0, 0, 1, 8'h33, 8'h00, 4'd7, 4'b0110);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #2;
            chk("st_StallM", StallM, 1);
            chk("st_mem_we", mif.mem_we, 1);
            chk("st_mem_addr", mif.mem_addr, 8'h20);
            chk("st_mem_wdata", mif.mem_wdata, 8'hA5);
            chk("st_ValidM", ValidM, 0);
            chk("st_FlagsM", FlagsM, 4'b1001);
        end
        tick();
        #2;
        chk("st_ack_StallM", StallM, 0);
        chk("st_ack_ValidM", ValidM, 1);
        chk("st_ack_FlagsM", FlagsM, 4'b1001);
        tick();
        put(0, 0, 0, 0, 0, '0, '0, '0, '0);
        #2;
        chk("held_ALUResultM", ALUResultM, 8'h33);
        chk("held_WA3M", WA3M, 7);
        chk("held_ValidM", ValidM, 1);
        chk("held_FlagsM", FlagsM, 4'b0110);

        // FlagWriteE=0: flags hold
        put(1, 0, 0, 0, 1, 8'h44, 8'h00, 4'd2, 4'b1111);
        tick();
        put(0, 0, 0, 0, 0, '0, '0, '0, '0);
        #2;
        chk("nofw_FlagsM", FlagsM, 4'b0110);
        chk("nofw_ALUResultM", ALUResultM, 8'h44);

        // Reset during the second wait cycle of a load
        lat_cfg = 5;
        put(1, 0, 1, 0, 1, 8'h50, 8'h00, 4'd9, 4'h0);
        tick();
        put(0, 0, 0, 0, 0, '0, '0, '0, '0);
        tick();
        #1;
        chk("mr_pre_StallM", StallM, 1);
        reset = 1'b1;
        #1;
        chk("mr_mem_req", mif.mem_req, 0);
        chk("mr_StallM", StallM, 0);
        chk("mr_ValidM", ValidM, 0);
        chk("mr_ALUResultM", ALUResultM, 0);
        chk("mr_ReadDataM", ReadDataM, 0);
        chk("mr_FlagsM", FlagsM, 0);
        chk("mr_RegWriteM", RegWriteM, 0);
        tick();
        reset         = 1'b0;
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 8'hEE;
        #2;
        chk("stray_mem_req", mif.mem_req, 0);
        chk("stray_ValidM", ValidM, 0);
        tick();
        #2;
        chk("stray_idle_req", mif.mem_req, 0);
        chk("stray_ReadDataM", ReadDataM, 0);

        // Randomized traffic; a stalled instruction is held upstream
        for (int i = 0; i < 2000; i++) begin
            tick();
            lat_cfg = $urandom_range(0, 3);
            reset   = ($urandom_range(0, 149) == 0);
            if (!prev_stall) begin
                int op;
                op = $urandom_range(0, 3);
                put($urandom_range(0, 4) != 0, 1'($urandom), op == 1, op == 2, 1'($urandom),
                    W'($urandom), W'($urandom), RA'($urandom), 4'($urandom));
            end
        end
        reset = 1'b0;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
